repeat_step_counter: RTL and testbench

REPEAT_STEP_COUNTER -- requirements
Module: repeat_step_counter

---
 rtl/repeat_step_counter_if.sv | 27 ++
 rtl/repeat_step_counter.sv | 143 ++++++++++++++
 tb/tb_repeat_step_counter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/repeat_step_counter_if.sv
// Control and status bundle for repeat_step_counter: level step requests, sign
// toggle, load strobe in; counter value and flags out.
interface repeat_step_counter_if #(
    parameter int Size = 5
);
    logic            Up;
    logic            Down;
    logic            Signe;
    logic            Load;
    logic [Size-1:0] LoadValue;
    logic [Size-2:0] Step;
    logic [Size-1:0] Data;
    logic            SigneBit;
    logic            AtMax;
    logic            AtMin;
    logic            Changed;

    modport master (
        output Up, Down, Signe, Load, LoadValue, Step,
        input  Data, SigneBit, AtMax, AtMin, Changed
    );

    modport slave (
        input  Up, Down, Signe, Load, LoadValue, Step,
        output Data, SigneBit, AtMax, AtMin, Changed
    );
endinterface

// File: rtl/repeat_step_counter.sv
// Up/down step counter with press-and-hold auto-repeat, in unsigned
// (saturating or wrapping) or sign-magnitude form.
//
// state  | meaning
// IDLE   | no direction held; a fresh Up xor Down steps at once
// HOLD   | direction held, waiting out the initial repeat delay
// REPEAT | direction still held, stepping every RepeatPeriod cycles
module repeat_step_counter #(
    parameter int    Size         = 5,
    parameter string Signed       = "No",
    parameter string Wrap         = "No",
    parameter int    RepeatDelay  = 8,
    parameter int    RepeatPeriod = 3
) (
    input logic                   Clock,
    input logic                   Reset,
    repeat_step_counter_if.slave  bus
);
    localparam bit SmEn   = (Signed == "Yes");
    localparam bit WrapEn = (Wrap == "Yes") && !SmEn;
    localparam int CntTop = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
    localparam int CW     = (CntTop > 2) ? $clog2(CntTop) : 1;

    localparam logic [CW-1:0]   DelayLd  = CW'(RepeatDelay - 1);
    localparam logic [CW-1:0]   PeriodLd = CW'(RepeatPeriod - 1);
    localparam logic [CW-1:0]   CntOne   = CW'(1);
    localparam logic [Size-1:0] MaxCode  = SmEn ? {1'b0, {(Size-1){1'b1}}} : {Size{1'b1}};
    localparam logic [Size-1:0] MinCode  = SmEn ? {Size{1'b1}} : {Size{1'b0}};

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [Size-1:0] data_q, data_d;
    logic            changed_q, changed_d;
    logic            signe_q, signe_d;

    logic            req, do_step, sign_rise;
    logic [Size:0]   sum_u, dif_u;
    logic [Size-1:0] step_u;
    logic [Size-2:0] mag, mag_new;
    logic [Size-1:0] sum_m;
    logic            sign_new, grow;
    logic [Size-1:0] step_sm, load_norm;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        do_step   = 1'b0;
        req       = bus.Up ^ bus.Down;
        signe_d   = bus.Signe;
        sign_rise = bus.Signe & ~signe_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    do_step = 1'b1;
                    state_d = HOLD;
                    cnt_d   = DelayLd;
                    dir_d   = bus.Up;
                end
            end
            default: begin
                if (!req || (bus.Up != dir_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    do_step = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = PeriodLd;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase

        // Unsigned arithmetic with one guard bit to detect overflow/underflow.
        sum_u = {1'b0, data_q} + {2'b0, bus.Step};
        dif_u = {1'b0, data_q} - {2'b0, bus.Step};
        if (dir_d) begin
            step_u = (sum_u[Size] && !WrapEn) ? {Size{1'b1}} : sum_u[Size-1:0];
        end else begin
            step_u = (dif_u[Size] && !WrapEn) ? {Size{1'b0}} : dif_u[Size-1:0];
        end

        // Sign-magnitude: moving away from zero grows the magnitude (clamped),
        // moving towards zero shrinks it and may cross to the other sign.
        mag   = data_q[Size-2:0];
        grow  = dir_d ^ data_q[Size-1];
        sum_m = {1'b0, mag} + {1'b0, bus.Step};
        if (grow) begin
            mag_new  = sum_m[Size-1] ? {(Size-1){1'b1}} : sum_m[Size-2:0];
            sign_new = data_q[Size-1];
        end else if (bus.Step <= mag) begin
            mag_new  = mag - bus.Step;
            sign_new = data_q[Size-1] && (mag_new != '0);
        end else begin
            mag_new  = bus.Step - mag;
            sign_new = ~data_q[Size-1];
        end
        step_sm = {sign_new, mag_new};

        load_norm = (SmEn && (bus.LoadValue[Size-2:0] == '0)) ? '0 : bus.LoadValue;

        data_d = data_q;
        if (bus.Load) begin
            data_d  = load_norm;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (SmEn && sign_rise && (mag != '0)) begin
            data_d = {~data_q[Size-1], mag};
        end else if (do_step) begin
            data_d = SmEn ? step_sm : step_u;
        end
        changed_d = (data_d != data_q);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            data_q    <= '0;
            changed_q <= 1'b0;
            signe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            changed_q <= changed_d;
            signe_q   <= signe_d;
        end
    end

    assign bus.Data     = data_q;
    assign bus.SigneBit = SmEn ? data_q[Size-1] : 1'b0;
    assign bus.AtMax    = (data_q == MaxCode);
    assign bus.AtMin    = (data_q == MinCode);
    assign bus.Changed  = changed_q;
endmodule

// File: tb/tb_repeat_step_counter.sv
// Bench for repeat_step_counter: unsigned-saturating, unsigned-wrapping and
// sign-magnitude instances share one stimulus stream; each record checks one.
module tb_repeat_step_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       up = 1'b0, dn = 1'b0, sg = 1'b0, ld = 1'b0;
    logic [4:0] lv = '0;
    logic [3:0] st = '0;

    repeat_step_counter_if #(.Size(5)) if_u ();
    repeat_step_counter_if #(.Size(5)) if_w ();
    repeat_step_counter_if #(.Size(5)) if_s ();

    assign if_u.Up = up;  assign if_u.Down = dn;  assign if_u.Signe = sg;
    assign if_u.Load = ld; assign if_u.LoadValue = lv; assign if_u.Step = st;
    assign if_w.Up = up;  assign if_w.Down = dn;  assign if_w.Signe = sg;
    assign if_w.Load = ld; assign if_w.LoadValue = lv; assign if_w.Step = st;
    assign if_s.Up = up;  assign if_s.Down = dn;  assign if_s.Signe = sg;
    assign if_s.Load = ld; assign if_s.LoadValue = lv; assign if_s.Step = st;

    repeat_step_counter #(.Size(5), .Signed("No"), .Wrap("No"), .RepeatDelay(8), .RepeatPeriod(3))
        dut_u (.Clock(clk), .Reset(rst), .bus(if_u));
    repeat_step_counter #(.Size(5), .Signed("No"), .Wrap("Yes"), .RepeatDelay(8), .RepeatPeriod(3))
        dut_w (.Clock(clk), .Reset(rst), .bus(if_w));
    repeat_step_counter #(.Size(5), .Signed("Yes"), .Wrap("No"), .RepeatDelay(8), .RepeatPeriod(3))
        dut_s (.Clock(clk), .Reset(rst), .bus(if_s));

    typedef struct {
        int         sel;   // 0 unsigned saturating, 1 unsigned wrapping, 2 sign-magnitude
        int         id;
        logic       rst, up, dn, sg, ld;
        logic [4:0] lv;
        logic [3:0] st;
        logic [4:0] d;
        logic       cc, ch, mx, mn, sb;
    } vec_t;

    vec_t  vecs[$];
    vec_t  sb_q[$];
    string names[$];
    int    total = 0;
    int    bad = 0;
    int    pulses;

    function automatic vec_t mk(int sel, logic r, logic u, logic d, logic s, logic l,
                                logic [4:0] lv_i, logic [3:0] st_i, logic [4:0] ed,
                                logic cc, logic ch, string nm);
        vec_t v;
        v.sel = sel; v.rst = r; v.up = u; v.dn = d; v.sg = s; v.ld = l;
        v.lv = lv_i; v.st = st_i; v.d = ed; v.cc = cc; v.ch = ch;
        v.mx = (sel == 2) ? (ed == 5'b01111) : (ed == 5'b11111);
        v.mn = (sel == 2) ? (ed == 5'b11111) : (ed == 5'b00000);
        v.sb = (sel == 2) ? ed[4] : 1'b0;
        names.push_back(nm);
        v.id = names.size() - 1;
        return v;
    endfunction

    task automatic chk(input string nm, input string what, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t       e;
        logic [4:0] ad;
        logic       ach, amx, amn, asb;
        rst = v.rst; up = v.up; dn = v.dn; sg = v.sg; ld = v.ld; lv = v.lv; st = v.st;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        case (e.sel)
            0:       begin ad = if_u.Data; ach = if_u.Changed; amx = if_u.AtMax; amn = if_u.AtMin; asb = if_u.SigneBit; end
            1:       begin ad = if_w.Data; ach = if_w.Changed; amx = if_w.AtMax; amn = if_w.AtMin; asb = if_w.SigneBit; end
            default: begin ad = if_s.Data; ach = if_s.Changed; amx = if_s.AtMax; amn = if_s.AtMin; asb = if_s.SigneBit; end
        endcase
        chk(names[e.id], "Data", int'(ad), int'(e.d));
        if (e.cc) chk(names[e.id], "Changed", int'(ach), int'(e.ch));
        chk(names[e.id], "AtMax", int'(amx), int'(e.mx));
        chk(names[e.id], "AtMin", int'(amn), int'(e.mn));
        chk(names[e.id], "SigneBit", int'(asb), int'(e.sb));
    endtask

    initial begin
        // sel  rst up dn sg ld  LoadValue  Step   expected Data cc ch
        vecs.push_back(mk(0, 1,0,0,0,0, 5'd0,     4'd0, 5'd0,     1,0, "reset_u"));
        vecs.push_back(mk(2, 1,0,0,0,0, 5'd0,     4'd0, 5'd0,     1,0, "reset_s"));
        vecs.push_back(mk(0, 0,0,0,0,1, 5'd30,    4'd0, 5'd30,    1,1, "u_load30"));
        vecs.push_back(mk(0, 0,1,0,0,0, 5'd0,     4'd4, 5'd31,    1,1, "u_sat_up1"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd4, 5'd31,    1,0, "u_release1"));
        vecs.push_back(mk(0, 0,1,0,0,0, 5'd0,     4'd4, 5'd31,    1,0, "u_sat_up2"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd4, 5'd31,    1,0, "u_release2"));
        vecs.push_back(mk(1, 0,0,0,0,1, 5'd30,    4'd0, 5'd30,    1,1, "w_load30"));
        vecs.push_back(mk(1, 0,1,0,0,0, 5'd0,     4'd4, 5'd2,     1,1, "w_wrap_up1"));
        vecs.push_back(mk(1, 0,0,0,0,0, 5'd0,     4'd4, 5'd2,     1,0, "w_release1"));
        vecs.push_back(mk(1, 0,1,0,0,0, 5'd0,     4'd4, 5'd6,     1,1, "w_wrap_up2"));
        vecs.push_back(mk(1, 0,0,0,0,0, 5'd0,     4'd4, 5'd6,     1,0, "w_release2"));
        vecs.push_back(mk(0, 0,0,0,0,1, 5'd5,     4'd0, 5'd5,     0,0, "u_load5"));
        vecs.push_back(mk(0, 0,1,0,0,0, 5'd0,     4'd0, 5'd5,     1,0, "u_step0"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd1, 5'd5,     1,0, "u_idle"));
        vecs.push_back(mk(0, 0,1,1,0,0, 5'd0,     4'd1, 5'd5,     1,0, "u_both"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd1, 5'd5,     1,0, "u_idle2"));
        vecs.push_back(mk(0, 0,0,0,0,1, 5'd2,     4'd0, 5'd2,     1,1, "u_load2"));
        vecs.push_back(mk(0, 0,0,1,0,0, 5'd0,     4'd3, 5'd0,     1,1, "u_sat_dn"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd3, 5'd0,     1,0, "u_release3"));
        vecs.push_back(mk(0, 0,0,0,1,0, 5'd0,     4'd3, 5'd0,     1,0, "u_signe"));
        vecs.push_back(mk(0, 0,0,0,0,0, 5'd0,     4'd3, 5'd0,     1,0, "u_signe_low"));
        vecs.push_back(mk(2, 0,0,0,0,1, 5'b00010, 4'd0, 5'b00010, 0,0, "s_load_p2"));
        vecs.push_back(mk(2, 0,0,1,0,0, 5'd0,     4'd3, 5'b10001, 1,1, "s_dn1"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd3, 5'b10001, 1,0, "s_release1"));
        vecs.push_back(mk(2, 0,0,1,0,0, 5'd0,     4'd3, 5'b10100, 1,1, "s_dn2"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd3, 5'b10100, 1,0, "s_release2"));
        vecs.push_back(mk(2, 0,0,0,1,0, 5'd0,     4'd3, 5'b00100, 1,1, "s_signe"));
        vecs.push_back(mk(2, 0,0,0,1,0, 5'd0,     4'd3, 5'b00100, 1,0, "s_signe_held"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd3, 5'b00100, 1,0, "s_signe_low"));
        vecs.push_back(mk(2, 0,0,0,0,1, 5'b11110, 4'd0, 5'b11110, 1,1, "s_load_m14"));
        vecs.push_back(mk(2, 0,0,1,0,0, 5'd0,     4'd5, 5'b11111, 1,1, "s_clamp_min"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd5, 5'b11111, 1,0, "s_release3"));
        vecs.push_back(mk(2, 0,0,1,0,0, 5'd0,     4'd5, 5'b11111, 1,0, "s_clamp_min2"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd5, 5'b11111, 1,0, "s_release4"));
        vecs.push_back(mk(2, 0,0,0,0,1, 5'b10000, 4'd0, 5'b00000, 1,1, "s_load_negzero"));
        vecs.push_back(mk(2, 0,0,0,1,0, 5'd0,     4'd0, 5'b00000, 1,0, "s_signe_zero"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd0, 5'b00000, 1,0, "s_signe_low2"));
        vecs.push_back(mk(2, 0,0,0,0,1, 5'b01110, 4'd0, 5'b01110, 1,1, "s_load_p14"));
        vecs.push_back(mk(2, 0,1,0,0,0, 5'd0,     4'd5, 5'b01111, 1,1, "s_clamp_max"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd5, 5'b01111, 1,0, "s_release5"));
        vecs.push_back(mk(2, 0,0,0,0,1, 5'b10011, 4'd0, 5'b10011, 1,1, "s_load_m3"));
        vecs.push_back(mk(2, 0,1,0,0,0, 5'd0,     4'd3, 5'b00000, 1,1, "s_to_zero"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd3, 5'b00000, 1,0, "s_release6"));
        vecs.push_back(mk(2, 0,1,0,0,0, 5'd0,     4'd1, 5'b00001, 1,1, "s_press"));
        vecs.push_back(mk(2, 0,1,0,0,1, 5'b10000, 4'd1, 5'b00000, 1,1, "s_load_over_up"));
        vecs.push_back(mk(2, 0,1,0,0,0, 5'd0,     4'd1, 5'b00001, 1,1, "s_repress"));
        vecs.push_back(mk(2, 0,0,0,0,0, 5'd0,     4'd1, 5'b00001, 1,0, "s_release7"));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Direction change while held: drop to IDLE without a step, then re-press.
        run_vec(mk(0, 0,0,0,0,1, 5'd10, 4'd0, 5'd10, 0,0, "dc_load10"));
        run_vec(mk(0, 0,1,0,0,0, 5'd0,  4'd1, 5'd11, 1,1, "dc_up"));
        run_vec(mk(0, 0,1,0,0,0, 5'd0,  4'd1, 5'd11, 1,0, "dc_up_hold"));
        run_vec(mk(0, 0,0,1,0,0, 5'd0,  4'd1, 5'd11, 1,0, "dc_switch"));
        run_vec(mk(0, 0,0,1,0,0, 5'd0,  4'd1, 5'd10, 1,1, "dc_repress"));
        run_vec(mk(0, 0,0,0,0,0, 5'd0,  4'd1, 5'd10, 1,0, "dc_release"));

        // Up held 20 cycles from 0: steps on cycles 0, 8, 11, 14, 17.
        run_vec(mk(0, 0,0,0,0,1, 5'd0, 4'd0, 5'd0, 1,1, "hold_load0"));
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            logic       is_step;
            logic [4:0] cnt_steps;
            is_step   = (k == 0) || (k >= 8 && ((k - 8) % 3 == 0));
            cnt_steps = 5'((k >= 0 ? 1 : 0) + (k >= 8 ? 1 : 0) + (k >= 11 ? 1 : 0) +
                           (k >= 14 ? 1 : 0) + (k >= 17 ? 1 : 0));
            run_vec(mk(0, 0,1,0,0,0, 5'd0, 4'd1, cnt_steps, 1, is_step, $sformatf("hold_c%0d", k)));
            if (if_u.Changed) pulses++;
        end
        chk("hold20", "pulses", pulses, 5);
        run_vec(mk(0, 0,0,0,0,0, 5'd0, 4'd1, 5'd5, 1,0, "hold_release"));

        // Reset mid-hold aborts the repeat; a still-held Up is a fresh press.
        run_vec(mk(0, 0,0,0,0,1, 5'd0, 4'd0, 5'd0, 1,1, "rh_load0"));
        for (int k = 0; k < 9; k++) begin
            run_vec(mk(0, 0,1,0,0,0, 5'd0, 4'd1, (k < 8) ? 5'd1 : 5'd2, 1, (k == 0 || k == 8),
                       $sformatf("rh_c%0d", k)));
        end
        run_vec(mk(0, 1,1,0,0,1, 5'd20, 4'd1, 5'd0, 1,0, "rh_reset"));
        run_vec(mk(0, 0,1,0,0,0, 5'd0,  4'd1, 5'd1, 1,1, "rh_first_edge"));
        run_vec(mk(0, 0,1,0,0,0, 5'd0,  4'd1, 5'd1, 1,0, "rh_hold"));
        run_vec(mk(0, 0,0,0,0,0, 5'd0,  4'd1, 5'd1, 1,0, "rh_release"));

        chk("scoreboard", "leftover", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
